// File: rtl/multi_cycle_shifter.sv
// ---------------------------------------------------------------------------
// multi_cycle_shifter
//   Iterative 32-bit barrel-shift replacement: SLL / SRL / SRA by 0..31,
//   retiring up to two bit positions per clock. op=11 passes the operand
//   through unchanged. Operands are captured when start is accepted in IDLE,
//   so later input changes cannot disturb an operation in flight.
//
// Ports
//   clk      in   1   clock, rising edge
//   rst      in   1   synchronous active-high reset
//   start    in   1   begin a shift (sampled only while idle)
//   in_data  in  32   operand
//   shamt    in   5   shift amount
//   op       in   2   00 SLL, 01 SRL, 10 SRA, 11 pass-through
//   busy     out  1   high whenever not idle
//   done     out  1   one-cycle completion strobe
//   out_data out 32   result, held until the next completion or reset
//
// shift_by_two
//   Shared left-shift-by-two helper used for the SLL double step.
//   data_i in 32 / data_o out 32 (data_o = data_i << 2)
// ---------------------------------------------------------------------------

module shift_by_two (
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);
    assign data_o = data_i << 2;
endmodule

module multi_cycle_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in_data,
    input  logic [4:0]  shamt,
    input  logic [1:0]  op,
    output logic        busy,
    output logic        done,
    output logic [31:0] out_data
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  rem_q, rem_d;
    logic [1:0]  opcode_q, opcode_d;
    logic        sign_q, sign_d;
    logic [31:0] out_q, out_d;

    logic [31:0] sll2;
    logic        step_two;
    logic [31:0] shifted;
    logic [4:0]  rem_next;

    shift_by_two u_sll2 (
        .data_i (work_q),
        .data_o (sll2)
    );

    // Two positions per step while at least two remain; the odd final
    // position of an odd shift amount is retired with a single-bit step.
    assign step_two = (rem_q >= 5'd2);
    assign rem_next = rem_q - (step_two ? 5'd2 : 5'd1);

    always_comb begin
        shifted = work_q;
        case (opcode_q)
            2'b00:   shifted = step_two ? sll2 : {work_q[30:0], 1'b0};
            2'b01:   shifted = step_two ? {2'b00, work_q[31:2]}
                                        : {1'b0, work_q[31:1]};
            // Fill from the sign captured at start, not from work_q[31].
            2'b10:   shifted = step_two ? {{2{sign_q}}, work_q[31:2]}
                                        : {sign_q, work_q[31:1]};
            default: shifted = work_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        rem_d    = rem_q;
        opcode_d = opcode_q;
        sign_d   = sign_q;
        out_d    = out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d   = in_data;
                    rem_d    = shamt;
                    opcode_d = op;
                    sign_d   = in_data[31];
                    if ((shamt != 5'd0) && (op != 2'b11)) begin
                        state_d = SHIFT;
                    end else begin
                        // Nothing to shift: the result is the operand itself,
                        // registered on the same edge that enters DONE.
                        state_d = DONE;
                        out_d   = in_data;
                    end
                end
            end
            SHIFT: begin
                work_d = shifted;
                rem_d  = rem_next;
                if (rem_next == 5'd0) begin
                    state_d = DONE;
                    out_d   = shifted;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            work_q   <= '0;
            rem_q    <= '0;
            opcode_q <= '0;
            sign_q   <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            opcode_q <= opcode_d;
            sign_q   <= sign_d;
            out_q    <= out_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign out_data = out_q;

endmodule
